// File: rtl/flash_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// flash_dump_ctrl_if
//
// Bundles the flash-navigator and UART-transmitter signals used by
// flash_dump_ctrl.
//
// Handshake semantics:
//   flash side : the controller raises flashReq for exactly one cycle with
//                flashReadAddr already valid and holds flashReadAddr until
//                the navigator answers with a one-cycle flashDataReady strobe,
//                during which flashData is valid. Only one read is ever
//                outstanding.
//   uart side  : the controller raises uartStart for exactly one cycle, only
//                when uartBusy was low. uartData is held from that cycle until
//                the transmitter has raised and then dropped uartBusy again.
//
// Modports:
//   master : controller side (drives requests and bytes)
//   slave  : flash navigator / UART side (drives data, strobes and busy)
// -----------------------------------------------------------------------------
interface flash_dump_ctrl_if #(
  parameter int ADDR_WIDTH    = 24,
  parameter int MEMORY_LENGTH = 2
);
  logic [ADDR_WIDTH-1:0]      flashReadAddr;
  logic                       flashReq;
  logic [MEMORY_LENGTH*8-1:0] flashData;
  logic                       flashDataReady;
  logic [7:0]                 uartData;
  logic                       uartStart;
  logic                       uartBusy;

  modport master (
    output flashReadAddr, flashReq, uartData, uartStart,
    input  flashData, flashDataReady, uartBusy
  );

  modport slave (
    input  flashReadAddr, flashReq, uartData, uartStart,
    output flashData, flashDataReady, uartBusy
  );
endinterface

// File: rtl/flash_dump_ctrl.sv
// -----------------------------------------------------------------------------
// flash_dump_ctrl
//
// Streams pages of external SPI flash out of the UART. A page is PAGE_READS
// flash words of MEMORY_LENGTH bytes each; every word is serialised MSB byte
// first. After reset the page at START_ADDR is dumped automatically. btn1
// advances to the next page and dumps it, btn2 replays the current page.
//
// Optional feature macro: FLASH_DUMP_HEX_EN
//   defined   : every byte goes out as two uppercase hex ASCII characters
//               (high nibble first) and each page ends with CR LF.
//   undefined : raw bytes, one UART frame per byte, no line ending.
//
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   btn1      : raw "next page" button, active-low, asynchronous
//   btn2      : raw "replay page" button, active-low, asynchronous
//   bus       : flash_dump_ctrl_if.master (flash read + UART transmit)
//   leds      : active-low LEDs, [4:0] = page index, [5] = busy dumping
//   dbg_state : current FSM state encoding
// -----------------------------------------------------------------------------
module flash_dump_ctrl #(
  parameter int                    ADDR_WIDTH      = 24,
  parameter int                    MEMORY_LENGTH   = 2,
  parameter int                    PAGE_READS      = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR      = '0,
  parameter int                    DEBOUNCE_CYCLES = 270000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn1,
  input  logic                     btn2,
  flash_dump_ctrl_if.master        bus,
  output logic [5:0]               leds,
  output logic [2:0]               dbg_state
);

  localparam int WORD_W = MEMORY_LENGTH * 8;

`ifdef FLASH_DUMP_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  // One output character covers a nibble in hex mode and a byte in raw mode.
  localparam int CHAR_BITS = HEX_EN ? 4 : 8;
  localparam int CHARS     = WORD_W / CHAR_BITS;
  localparam int CCW       = $clog2(CHARS + 1);
  localparam int RCW       = (PAGE_READS > 1) ? $clog2(PAGE_READS) : 1;
  localparam int DCW       = $clog2(DEBOUNCE_CYCLES);

  localparam logic [ADDR_WIDTH-1:0] PAGE_STEP = ADDR_WIDTH'(PAGE_READS * MEMORY_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(MEMORY_LENGTH);
  localparam logic [DCW-1:0]        DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0]        READ_LAST = RCW'(PAGE_READS - 1);
  localparam logic [CCW-1:0]        CHAR_END  = CCW'(CHARS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    WAIT_FLASH = 3'd2,
    SEND       = 3'd3,
    WAIT_UART  = 3'd4,
    EOL        = 3'd5
  } state_t;

  state_t state, state_d;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers. Index 0 = btn1, index 1 = btn2.
  // db_level is the accepted (debounced) level; db_cnt counts consecutive
  // cycles in which the synchronised level disagrees with it. Any agreeing
  // cycle (a bounce) restarts the count.
  // ---------------------------------------------------------------------------
  logic [1:0]     btn_raw;
  logic [1:0]     sync_a, sync_b;
  logic [1:0]     db_level;
  logic [DCW-1:0] db_cnt [2];
  logic [1:0]     press;

  assign btn_raw = {btn2, btn1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a    <= 2'b11;
      sync_b    <= 2'b11;
      db_level  <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync_b[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the accepted 1 -> 0 transition; releases produce no event.
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = db_level[i] & ~sync_b[i] & (db_cnt[i] == DB_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / control registers
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  flash_req_q;
  logic [7:0]            uart_data_q;
  logic                  uart_start_q;
  logic [WORD_W-1:0]     shreg;
  logic [RCW-1:0]        read_cnt;
  logic [CCW-1:0]        char_cnt;
  logic [1:0]            eol_cnt;
  logic [4:0]            page_idx;
  logic                  pend_next;
  logic                  pend_replay;
  logic                  auto_dump;

  // Control strobes from the output process
  logic       idle_go;
  logic       do_fetch;
  logic       do_capture;
  logic       do_send;
  logic       do_eol;
  logic       next_read;
  logic       uart_done;
  logic       last_read;
  logic [7:0] char_now;

  assign last_read = (read_cnt == READ_LAST);

  // uart_start_q is high exactly in the first WAIT_UART cycle, so it doubles
  // as the "ignore busy this cycle" marker while the UART raises busy.
  assign uart_done = !uart_start_q && !bus.uartBusy;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (auto_dump || pend_next || pend_replay) state_d = FETCH;
      end
      FETCH: begin
        state_d = WAIT_FLASH;
      end
      WAIT_FLASH: begin
        if (bus.flashDataReady) state_d = SEND;
      end
      SEND: begin
        if (!bus.uartBusy) state_d = WAIT_UART;
      end
      WAIT_UART: begin
        if (uart_done) begin
          if (eol_cnt != 2'd0) begin
            // Line-ending phase: two characters, then back to IDLE.
            state_d = (eol_cnt == 2'd2) ? IDLE : EOL;
          end else if (char_cnt != CHAR_END) begin
            state_d = SEND;
          end else if (!last_read) begin
            state_d = FETCH;
          end else begin
            state_d = HEX_EN ? EOL : IDLE;
          end
        end
      end
      EOL: begin
        if (!bus.uartBusy) state_d = WAIT_UART;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output / control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    idle_go    = 1'b0;
    do_fetch   = 1'b0;
    do_capture = 1'b0;
    do_send    = 1'b0;
    do_eol     = 1'b0;
    next_read  = 1'b0;
    case (state)
      IDLE:       idle_go    = auto_dump || pend_next || pend_replay;
      FETCH:      do_fetch   = 1'b1;
      WAIT_FLASH: do_capture = bus.flashDataReady;
      SEND:       do_send    = !bus.uartBusy;
      WAIT_UART:  next_read  = uart_done && (eol_cnt == 2'd0) &&
                               (char_cnt == CHAR_END) && !last_read;
      EOL:        do_eol     = !bus.uartBusy;
      default:    ;
    endcase
  end

  // Character currently at the top of the shift register.
`ifdef FLASH_DUMP_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 0-9 -> '0'..'9', A-F -> 'A'..'F' (0x37 + 0xA = 0x41)
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign char_now = hex_char(shreg[WORD_W-1 -: 4]);
`else
  assign char_now = shreg[WORD_W-1 -: 8];
`endif

  // ---------------------------------------------------------------------------
  // Registered datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base         <= START_ADDR;
      addr_q       <= START_ADDR;
      flash_req_q  <= 1'b0;
      uart_data_q  <= 8'h00;
      uart_start_q <= 1'b0;
      shreg        <= '0;
      read_cnt     <= '0;
      char_cnt     <= '0;
      eol_cnt      <= 2'd0;
      page_idx     <= 5'd0;
      pend_next    <= 1'b0;
      pend_replay  <= 1'b0;
      auto_dump    <= 1'b1;
    end else begin
      // Both strobes are single-cycle pulses by construction.
      flash_req_q  <= do_fetch;
      uart_start_q <= do_send || do_eol;

      // Pending flags are one deep; a press while set changes nothing.
      // Leaving IDLE consumes everything, so a replay queued alongside a
      // next is discarded.
      if (idle_go) begin
        pend_next   <= 1'b0;
        pend_replay <= 1'b0;
        auto_dump   <= 1'b0;
        read_cnt    <= '0;
        eol_cnt     <= 2'd0;
        if (pend_next) begin
          base     <= base + PAGE_STEP;
          page_idx <= page_idx + 5'd1;
        end
      end else begin
        if (press[0]) pend_next   <= 1'b1;
        if (press[1]) pend_replay <= 1'b1;
      end

      if (do_fetch) begin
        addr_q <= base + ADDR_WIDTH'(read_cnt) * WORD_STEP;
      end

      if (do_capture) begin
        shreg    <= bus.flashData;
        char_cnt <= '0;
      end

      if (do_send) begin
        uart_data_q <= char_now;
        shreg       <= shreg << CHAR_BITS;
        char_cnt    <= char_cnt + 1'b1;
      end

      if (do_eol) begin
        uart_data_q <= (eol_cnt == 2'd0) ? 8'h0D : 8'h0A;
        eol_cnt     <= eol_cnt + 2'd1;
      end

      if (next_read) begin
        read_cnt <= read_cnt + 1'b1;
      end
    end
  end

  assign bus.flashReadAddr = addr_q;
  assign bus.flashReq      = flash_req_q;
  assign bus.uartData      = uart_data_q;
  assign bus.uartStart     = uart_start_q;

  assign leds      = {~(state != IDLE), ~page_idx};
  assign dbg_state = state;

endmodule

// File: tb/tb_flash_dump_ctrl.sv
module tb_flash_dump_ctrl;

  localparam int AW = 24;
  localparam int ML = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       b1, b2, b1w, b2w;
  logic [5:0] leds0, leds1;
  logic [2:0] dbg0, dbg1;

  flash_dump_ctrl_if #(.ADDR_WIDTH(AW), .MEMORY_LENGTH(ML)) if0 ();
  flash_dump_ctrl_if #(.ADDR_WIDTH(AW), .MEMORY_LENGTH(ML)) if1 ();

  flash_dump_ctrl #(
    .ADDR_WIDTH(AW), .MEMORY_LENGTH(ML), .PAGE_READS(2),
    .START_ADDR(24'h000000), .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk(clk), .reset(rst_n), .btn1(b1), .btn2(b2),
    .bus(if0), .leds(leds0), .dbg_state(dbg0)
  );

  flash_dump_ctrl #(
    .ADDR_WIDTH(AW), .MEMORY_LENGTH(ML), .PAGE_READS(2),
    .START_ADDR(24'hFFFFFC), .DEBOUNCE_CYCLES(4)
  ) u_wrap (
    .clk(clk), .reset(rst_n), .btn1(b1w), .btn2(b2w),
    .bus(if1), .leds(leds1), .dbg_state(dbg1)
  );

  // ---------------- flash / uart models ----------------
  function automatic logic [15:0] mem(input logic [AW-1:0] a);
    case (a[2:1])
      2'd0:    mem = 16'hA55A;
      2'd1:    mem = 16'h0F10;
      2'd2:    mem = 16'h1234;
      default: mem = 16'hBEEF;
    endcase
  endfunction

  logic [AW-1:0] addr_q0[$], addr_q1[$];
  logic [7:0]    byte_q0[$], byte_q1[$];
  logic [2:0]    f0_cnt, f1_cnt;
  logic [AW-1:0] f0_addr, f1_addr;
  int            u0_cnt, u1_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      f0_cnt <= 3'd0;
      if0.flashDataReady <= 1'b0;
    end else begin
      if0.flashDataReady <= 1'b0;
      if (if0.flashReq) begin
        f0_addr <= if0.flashReadAddr;
        f0_cnt  <= 3'd3;
        addr_q0.push_back(if0.flashReadAddr);
      end else if (f0_cnt != 3'd0) begin
        f0_cnt <= f0_cnt - 3'd1;
        if (f0_cnt == 3'd1) begin
          if0.flashDataReady <= 1'b1;
          if0.flashData      <= mem(f0_addr);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      f1_cnt <= 3'd0;
      if1.flashDataReady <= 1'b0;
    end else begin
      if1.flashDataReady <= 1'b0;
      if (if1.flashReq) begin
        f1_addr <= if1.flashReadAddr;
        f1_cnt  <= 3'd3;
        addr_q1.push_back(if1.flashReadAddr);
      end else if (f1_cnt != 3'd0) begin
        f1_cnt <= f1_cnt - 3'd1;
        if (f1_cnt == 3'd1) begin
          if1.flashDataReady <= 1'b1;
          if1.flashData      <= mem(f1_addr);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) u0_cnt <= 0;
    else if (if0.uartStart) begin
      u0_cnt <= 20;
      byte_q0.push_back(if0.uartData);
    end else if (u0_cnt != 0) u0_cnt <= u0_cnt - 1;
  end

  always @(posedge clk) begin
    if (!rst_n) u1_cnt <= 0;
    else if (if1.uartStart) begin
      u1_cnt <= 20;
      byte_q1.push_back(if1.uartData);
    end else if (u1_cnt != 0) u1_cnt <= u1_cnt - 1;
  end

  assign if0.uartBusy = (u0_cnt != 0);
  assign if1.uartBusy = (u1_cnt != 0);

  // ---------------- expected data ----------------
`ifdef FLASH_DUMP_HEX_EN
  localparam int NB = 10;
  logic [7:0] pg_a [NB] = '{8'h41, 8'h35, 8'h35, 8'h41, 8'h30, 8'h46, 8'h31, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] pg_b [NB] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
`else
  localparam int NB = 4;
  logic [7:0] pg_a [NB] = '{8'hA5, 8'h5A, 8'h0F, 8'h10};
  logic [7:0] pg_b [NB] = '{8'h12, 8'h34, 8'hBE, 8'hEF};
`endif

  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- helpers ----------------
  task automatic load_exp(input bit use_b, input bit append);
    if (!append) exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(use_b ? pg_b[i] : pg_a[i]);
  endtask

  task automatic clear_obs();
    addr_q0.delete(); byte_q0.delete();
    addr_q1.delete(); byte_q1.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int which);
    logic [7:0] got[$];
    if (which == 0) got = byte_q0; else got = byte_q1;
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic check_addrs(input string tag, input int which);
    logic [AW-1:0] got[$];
    if (which == 0) got = addr_q0; else got = addr_q1;
    check({tag, "_count"}, got.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < got.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), {8'h0, got[i]}, {8'h0, exp_addr_q[i]});
  endtask

  // Wait until n bytes were transmitted and the controller is back in IDLE.
  task automatic wait_done(input int which, input int n);
    int  cyc;
    int  sz;
    logic [2:0] st;
    cyc = 0;
    forever begin
      sz = (which == 0) ? byte_q0.size() : byte_q1.size();
      st = (which == 0) ? dbg0 : dbg1;
      if ((sz >= n && st == 3'd0) || cyc >= 3000) break;
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    assert (cyc < 3000) else begin
      n_fail++;
      $error("FAIL wait_done%0d: timed out with %0d bytes, required %0d", which, sz, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_state0(input logic [2:0] s);
    int cyc;
    cyc = 0;
    while (dbg0 != s && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    assert (cyc < 1000) else begin
      n_fail++;
      $error("FAIL wait_state: observed %0d required %0d", dbg0, s);
    end
  endtask

  // sel: 1 = btn1, 2 = btn2, 3 = both, 4 = wrap instance btn1
  task automatic press(input int sel, input int cycles);
    @(negedge clk);
    if (sel == 1 || sel == 3) b1 = 1'b0;
    if (sel == 2 || sel == 3) b2 = 1'b0;
    if (sel == 4) b1w = 1'b0;
    repeat (cycles) @(negedge clk);
    b1 = 1'b1; b2 = 1'b1; b1w = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    b1 = 1'b1; b2 = 1'b1; b1w = 1'b1; b2w = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_addr",      {8'h0, if0.flashReadAddr}, 32'h000000);
    check("rst_req",       {31'h0, if0.flashReq},     32'h0);
    check("rst_udata",     {24'h0, if0.uartData},     32'h0);
    check("rst_ustart",    {31'h0, if0.uartStart},    32'h0);
    check("rst_leds",      {26'h0, leds0},            32'h3F);
    check("rst_state",     {29'h0, dbg0},             32'h0);
    check("rst_wrap_addr", {8'h0, if1.flashReadAddr}, 32'hFFFFFC);

    // Auto dump after reset release
    rst_n = 1'b1;
    wait_done(0, NB);
    exp_addr_q = {24'h000000, 24'h000002};
    check_addrs("auto", 0);
    load_exp(1'b0, 1'b0);
    check_bytes("auto", 0);
    check("auto_leds", {26'h0, leds0}, 32'h3F);
    wait_done(1, NB);
    exp_addr_q = {24'hFFFFFC, 24'hFFFFFE};
    check_addrs("wrap_auto", 1);

    // btn1 -> next page
    clear_obs();
    press(1, 10);
    wait_done(0, NB);
    exp_addr_q = {24'h000004, 24'h000006};
    check_addrs("next", 0);
    load_exp(1'b1, 1'b0);
    check_bytes("next", 0);
    check("next_leds", {26'h0, leds0}, 32'h3E);

    // Short btn2 press is filtered out
    clear_obs();
    press(2, 3);
    repeat (60) @(negedge clk);
    check("short_addrs", addr_q0.size(), 0);
    check("short_bytes", byte_q0.size(), 0);
    check("short_state", {29'h0, dbg0}, 32'h0);

    // Long btn2 press -> replay current page
    press(2, 10);
    wait_done(0, NB);
    exp_addr_q = {24'h000004, 24'h000006};
    check_addrs("replay", 0);
    load_exp(1'b1, 1'b0);
    check_bytes("replay", 0);
    check("replay_leds", {26'h0, leds0}, 32'h3E);

    // Both buttons during a dump -> only the next page follows
    clear_obs();
    press(2, 10);
    wait_state0(3'd4);
    check("busy_led", {31'h0, leds0[5]}, 32'h0);
    press(3, 10);
    wait_done(0, 2 * NB);
    repeat (150) @(negedge clk);
    exp_addr_q = {24'h000004, 24'h000006, 24'h000008, 24'h00000A};
    check_addrs("both", 0);
    load_exp(1'b1, 1'b0);
    load_exp(1'b0, 1'b1);
    check_bytes("both", 0);
    check("both_leds", {26'h0, leds0}, 32'h3D);

    // Address wrap on the START_ADDR=FFFFFC instance
    clear_obs();
    press(4, 10);
    wait_done(1, NB);
    exp_addr_q = {24'h000000, 24'h000002};
    check_addrs("wrap", 1);
    load_exp(1'b0, 1'b0);
    check_bytes("wrap", 1);
    check("wrap_leds", {26'h0, leds1}, 32'h3E);

    // Reset in the middle of a dump
    press(2, 10);
    wait_state0(3'd4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ustart", {31'h0, if0.uartStart},    32'h0);
    check("midrst_req",    {31'h0, if0.flashReq},     32'h0);
    check("midrst_leds",   {26'h0, leds0},            32'h3F);
    check("midrst_addr",   {8'h0, if0.flashReadAddr}, 32'h000000);
    repeat (3) @(negedge clk);
    check("midrst_hold_leds", {26'h0, leds0}, 32'h3F);
    clear_obs();
    rst_n = 1'b1;
    wait_done(0, NB);
    exp_addr_q = {24'h000000, 24'h000002};
    check_addrs("postrst", 0);
    load_exp(1'b0, 1'b0);
    check_bytes("postrst", 0);
    check("postrst_leds", {26'h0, leds0}, 32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
